// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver. It synchronizes ps2_clk and detects its falling
// edges, assembles 11-bit frames and checks their start, parity and stop bits.
// Good scan codes are buffered in a small FIFO with a combinational head read.
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

  // ---------------------------------------------------------------------------
  // ps2_clk synchronizer and falling-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_fall;

  // First synchronizer stage captures the raw pin
  always_ff @(posedge clk) begin
    if (rst) r_sync[0] <= 1'b0;
    else     r_sync[0] <= ps2_clk;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      // Remaining synchronizer stages shift the sample along
      always_ff @(posedge clk) begin
        if (rst) r_sync[gi] <= 1'b0;
        else     r_sync[gi] <= r_sync[gi-1];
      end
    end
  endgenerate

  // The oldest stage still high while the next one is already low marks a
  // single-cycle falling edge.
  assign w_fall = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  logic [0:0]    r_state;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_frame;
  logic [IW-1:0] r_idle_cnt;

  logic       w_frame_done;
  logic       w_frame_ok;
  logic [7:0] w_rx_byte;

  // The 11th falling edge carries the stop bit. It is taken straight from the
  // pin and is never stored in r_frame.
  assign w_frame_done = w_fall && (r_state == S_RECV) && (r_bit_cnt == 4'd10);
  assign w_rx_byte    = r_frame[8:1];
  assign w_frame_ok   = ~r_frame[0] & (^r_frame[9:1]) & ps2_data;

  // Bit counter, shift register and inter-bit timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_frame    <= 10'd0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idle_cnt <= '0;
          if (w_fall) begin
            r_frame   <= {ps2_data, r_frame[9:1]};
            r_bit_cnt <= 4'd1;
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_fall) begin
            r_idle_cnt <= '0;
            if (r_bit_cnt == 4'd10) begin
              r_bit_cnt <= 4'd0;
              r_state   <= S_IDLE;
            end else begin
              r_frame   <= {ps2_data, r_frame[9:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else if (r_idle_cnt == IDLE_LIMIT) begin
            // The keyboard went quiet mid-frame, so drop the partial frame silently.
            r_idle_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_state    <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_bad;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push  = w_frame_done & w_frame_ok & (~w_full | w_pop);
  assign w_drop  = w_frame_done & w_frame_ok & w_full & ~w_pop;
  assign w_bad   = w_frame_done & ~w_frame_ok;

  // Storage array. It is not reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr[AW-1:0]] <= w_rx_byte;
  end

  // Read and write pointers with the extra wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Sticky error flags. A new event in the same cycle as a clear wins over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end
      if (w_drop) overflow  <= 1'b1;
      if (w_bad)  frame_err <= 1'b1;
    end
  end

  assign ready = ~w_empty;
  assign data  = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx. A queue-based model predicts the
// FIFO contents and the flags. A per-cycle compare process checks the DUT
// against that model, and directed literal checks pin the model itself.
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TOUT  = 4095;
  localparam int H     = 10;   // clk cycles per PS/2 half period

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_keyboard_rx #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .data     (data),
    .ready    (ready),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench state
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  bit         cmp_on  = 0;
  bit         rand_on = 0;
  int         rd_pct  = 0;
  int         pop_at  = -100;

  // Model: expected FIFO contents, flags and the one pending frame decision
  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_err = 0;
  bit         ev_armed = 0;
  bit         ev_valid = 0;
  logic [7:0] ev_byte = 8'h00;
  int         ev_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model update on each rising edge. The pop happens first so that a full
  // FIFO can accept a push in the same cycle.
  initial begin
    bit pop;
    bit set_o;
    bit set_e;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_ovf    = 0;
        m_err    = 0;
        ev_armed = 0;
      end else begin
        pop   = rd_en && (q.size() > 0);
        set_o = 0;
        set_e = 0;
        if (pop) void'(q.pop_front());
        if (ev_armed && ev_cyc == cyc) begin
          ev_armed = 0;
          if (!ev_valid)               set_e = 1;
          else if (q.size() >= DEPTH)  set_o = 1;
          else                         q.push_back(ev_byte);
        end
        if (clr_err) begin
          m_ovf = 0;
          m_err = 0;
        end
        if (set_o) m_ovf = 1;
        if (set_e) m_err = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("ready", ready, (q.size() > 0) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
        chk("frame_err", frame_err, m_err);
        if (q.size() > 0) chk("data", data, q[0]);
      end
    end
  end

  // One bench cycle. Inputs change on the falling edge.
  task automatic tick(input bit rd, input bit clr);
    @(negedge clk);
    if (rand_on) begin
      rd_en   = ($urandom_range(0, 99) < rd_pct);
      clr_err = ($urandom_range(0, 15) == 0);
    end else begin
      rd_en   = rd || (cyc == pop_at);
      clr_err = clr;
    end
  endtask

  // kind: 0 good, 1 bad start, 2 bad parity, 3 bad stop
  function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    case (kind)
      1: f[0]  = 1'b1;
      2: f[9]  = ~f[9];
      3: f[10] = 1'b0;
      default: ;
    endcase
    return f;
  endfunction

  // Drives nbits of a frame. When sched is set, the bench registers the
  // decision the receiver must make SYNC edges after the stop-bit clock falls.
  task automatic send_bits(input logic [10:0] fr, input int nbits, input bit sched,
                           input bit pop_on_stop);
    for (int i = 0; i < nbits; i++) begin
      tick(0, 0);
      ps2_data = fr[i];
      repeat (H - 1) tick(0, 0);
      ps2_clk = 1'b0;
      if (i == 10 && sched) begin
        ev_byte  = fr[8:1];
        ev_valid = (fr[0] == 1'b0) && ((^fr[9:1]) == 1'b1) && (fr[10] == 1'b1);
        ev_cyc   = cyc + SYNC;
        ev_armed = 1;
        if (pop_on_stop) pop_at = ev_cyc - 1;
      end
      repeat (H) tick(0, 0);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) tick(0, 0);
    pop_at = -100;
  endtask

  task automatic send_byte(input logic [7:0] b, input int kind, input bit pop_on_stop);
    send_bits(make_frame(b, kind), 11, 1, pop_on_stop);
  endtask

  task automatic pop_one();
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic clear_flags();
    tick(0, 1);
    tick(0, 0);
  endtask

  task automatic do_reset();
    tick(0, 0);
    rst = 1'b1;
    tick(0, 0);
    rst = 1'b0;
    repeat (SYNC + 2) tick(0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    tick(0, 0);
    cmp_on = 1;
    tick(0, 0);
    chk("reset_ready", ready, 0);
    chk("reset_data", data, 8'h00);
    chk("reset_overflow", overflow, 0);
    chk("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (SYNC + 2) tick(0, 0);

    // Single frame
    send_byte(8'h1C, 0, 0);
    chk("single_ready", ready, 1);
    chk("single_data", data, 8'h1C);
    pop_one();
    chk("single_ready_after_pop", ready, 0);

    // Bad parity, then clear
    send_byte(8'h1C, 2, 0);
    chk("parity_frame_err", frame_err, 1);
    chk("parity_ready", ready, 0);
    clear_flags();
    chk("parity_cleared", frame_err, 0);

    // Overflow
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 0, 0);
    chk("ovf_flag", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_read", data, 32'(i));
      pop_one();
    end
    chk("ovf_empty", ready, 0);
    clear_flags();

    // Full FIFO with a pop in the push cycle
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0, 0);
    send_byte(8'h09, 0, 1);
    chk("fullpop_ovf", overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      chk("fullpop_read", data, 32'(i));
      pop_one();
    end
    chk("fullpop_empty", ready, 0);

    // Reset mid-frame discards buffered bytes and the partial frame
    send_byte(8'h11, 0, 0);
    send_bits(make_frame(8'h55, 0), 5, 0, 0);
    do_reset();
    chk("rst_flush", ready, 0);
    send_byte(8'hF0, 0, 0);
    chk("rst_data", data, 8'hF0);
    pop_one();
    chk("rst_one_byte", ready, 0);
    chk("rst_no_ovf", overflow, 0);
    chk("rst_no_err", frame_err, 0);

    // Timeout resynchronization
    send_bits(make_frame(8'hAA, 0), 4, 0, 0);
    repeat (TOUT + 100) tick(0, 0);
    send_byte(8'h2D, 0, 0);
    chk("tout_data", data, 8'h2D);
    chk("tout_err", frame_err, 0);
    pop_one();

    // Randomized frames with random pops and clears
    rand_on = 1;
    for (int f = 0; f < 40; f++) begin
      int k;
      int sel;
      sel = $urandom_range(0, 3);
      rd_pct = (sel == 0) ? 0 : (sel == 1) ? 10 : (sel == 2) ? 30 : 60;
      k = $urandom_range(0, 9);
      send_byte(8'($urandom), (k < 7) ? 0 : k - 6, 0);
      repeat ($urandom_range(0, 20)) tick(0, 0);
    end
    rand_on = 0;
    repeat (DEPTH + 4) tick(1, 0);
    tick(0, 0);
    chk("drain_empty", ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
